// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo back-end types: func encodings, CDB entry layout, ALU helper.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
//
// The CDB field widths live here so every unit that drives or snoops the CDB
// agrees on one entry layout; execution units default their width parameters
// to these values.
package tomasulo_pkg;

  localparam int CDB_DATA_W = 8;
  localparam int CDB_TAG_W  = 3;
  localparam int CDB_RS_W   = 3;
  localparam int CDB_REG_W  = 4;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_AND = 4'b0010;
  localparam logic [3:0] FUNC_OR  = 4'b0011;
  localparam logic [3:0] FUNC_XOR = 4'b0100;

  typedef struct packed {
    logic [CDB_DATA_W-1:0] result;
    logic                  carry;
    logic                  illegal;
    logic [CDB_TAG_W-1:0]  rob;
    logic [CDB_RS_W-1:0]   rs_idx;
    logic [CDB_REG_W-1:0]  rd;
  } cdb_entry_t;

  // Computes one add/sub/logic operation and packs it with its tags.
  // SUB carry is the borrow: the extra top bit of the widened difference is
  // set exactly when rs1 < rs2 (unsigned).
  function automatic cdb_entry_t exec_op(
    input logic [3:0]            func,
    input logic [CDB_DATA_W-1:0] a,
    input logic [CDB_DATA_W-1:0] b,
    input logic [CDB_TAG_W-1:0]  rob,
    input logic [CDB_RS_W-1:0]   rs_idx,
    input logic [CDB_REG_W-1:0]  rd
  );
    cdb_entry_t          e;
    logic [CDB_DATA_W:0] wide;
    e        = '0;
    wide     = '0;
    e.rob    = rob;
    e.rs_idx = rs_idx;
    e.rd     = rd;
    case (func)
      FUNC_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        e.result = wide[CDB_DATA_W-1:0];
        e.carry  = wide[CDB_DATA_W];
      end
      FUNC_SUB: begin
        wide     = {1'b0, a} - {1'b0, b};
        e.result = wide[CDB_DATA_W-1:0];
        e.carry  = wide[CDB_DATA_W];
      end
      FUNC_AND: e.result = a & b;
      FUNC_OR:  e.result = a | b;
      FUNC_XOR: e.result = a ^ b;
      default:  e.illegal = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/exec_result_fifo.sv
// In-order result queue with synchronous flush; head is a registered-array read.
// Latency: an entry pushed in cycle T is at the head from T+1.
// Backpressure: none internally; the owner must not push when full nor pop when empty.
//
// Ports: clk, rst (sync, active-high), flush (sync clear), push/push_dat,
//        pop, head_vld (non-empty), head_dat (oldest entry).
module exec_result_fifo
  import tomasulo_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cdb_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output logic head_vld,
  output T     head_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until the pointers say so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_vld = (cnt != '0);
  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/addsub_exec_unit.sv
// Pipelined add/sub/logic execution unit feeding the CDB in issue order.
// Latency: accept in cycle T -> result on cdb_* from cycle T+LAT.
// Backpressure: in_ready drops when LAT stages + queue hold Q_DEPTH ops; cdb_* hold while !cdb_ready.
//
// Ports: clk, rst (sync, active-high), flush; issue side in_valid/in_ready with
//        in_func, in_rs1, in_rs2, in_rob, in_rs_idx, in_rd; CDB side
//        cdb_valid/cdb_ready with cdb_result, cdb_carry, cdb_illegal,
//        cdb_rob, cdb_rs_idx, cdb_rd; occ = operations currently held.
module addsub_exec_unit
  import tomasulo_pkg::*;
#(
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int RS_W    = CDB_RS_W,
  parameter int REG_W   = CDB_REG_W,
  parameter int LAT     = 2,
  parameter int Q_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_func,
  input  logic [DATA_W-1:0]            in_rs1,
  input  logic [DATA_W-1:0]            in_rs2,
  input  logic [TAG_W-1:0]             in_rob,
  input  logic [RS_W-1:0]              in_rs_idx,
  input  logic [REG_W-1:0]             in_rd,
  output logic                         cdb_valid,
  input  logic                         cdb_ready,
  output logic [DATA_W-1:0]            cdb_result,
  output logic                         cdb_carry,
  output logic                         cdb_illegal,
  output logic [TAG_W-1:0]             cdb_rob,
  output logic [RS_W-1:0]              cdb_rs_idx,
  output logic [REG_W-1:0]             cdb_rd,
  output logic [$clog2(Q_DEPTH+1)-1:0] occ
);

  localparam int OCC_W = $clog2(Q_DEPTH + 1);

  // The entry layout is shared through tomasulo_pkg, so the width parameters
  // must agree with it.
  if (DATA_W != CDB_DATA_W || TAG_W != CDB_TAG_W ||
      RS_W != CDB_RS_W || REG_W != CDB_REG_W) begin : g_width_check
    $error("addsub_exec_unit: field widths must match tomasulo_pkg");
  end
  if (LAT < 1 || Q_DEPTH < 1) begin : g_param_check
    $error("addsub_exec_unit: LAT and Q_DEPTH must be >= 1");
  end

  logic             accept;
  logic             pop;
  logic [LAT-1:0]   pipe_vld;
  cdb_entry_t       pipe_ent [LAT];
  logic             tail_vld;
  logic             fifo_vld;
  logic             fifo_push;
  logic             fifo_pop;
  cdb_entry_t       fifo_head;
  cdb_entry_t       head_ent;
  logic [OCC_W-1:0] occ_q;

  // occ counts everything from accept to pop, so it bounds the queue fill and
  // in_ready never looks at cdb_ready.
  assign in_ready = (occ_q < OCC_W'(Q_DEPTH)) && !flush;
  assign accept   = in_valid && in_ready;
  assign pop      = cdb_valid && cdb_ready;

  // Stage 0 computes; later stages only delay.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int k = 1; k < LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pipe_ent[0] <= exec_op(in_func, in_rs1, in_rs2, in_rob, in_rs_idx, in_rd);
    for (int k = 1; k < LAT; k++) pipe_ent[k] <= pipe_ent[k-1];
  end

  // The pipeline tail bypasses the queue when the queue is empty and the CDB
  // takes it right away; otherwise it is parked in the queue behind older
  // results. The queue never overflows because occ caps total occupancy.
  assign tail_vld  = pipe_vld[LAT-1];
  assign cdb_valid = fifo_vld || tail_vld;
  assign fifo_pop  = pop && fifo_vld;
  assign fifo_push = tail_vld && (fifo_vld || !cdb_ready);

  exec_result_fifo #(
    .DEPTH (Q_DEPTH),
    .T     (cdb_entry_t)
  ) u_result_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (fifo_push),
    .push_dat (pipe_ent[LAT-1]),
    .pop      (fifo_pop),
    .head_vld (fifo_vld),
    .head_dat (fifo_head)
  );

  // Zero the data fields when idle so nothing stale is ever presented.
  always_comb begin
    head_ent = '0;
    if (fifo_vld)      head_ent = fifo_head;
    else if (tail_vld) head_ent = pipe_ent[LAT-1];
  end

  assign cdb_result  = head_ent.result;
  assign cdb_carry   = head_ent.carry;
  assign cdb_illegal = head_ent.illegal;
  assign cdb_rob     = head_ent.rob;
  assign cdb_rs_idx  = head_ent.rs_idx;
  assign cdb_rd      = head_ent.rd;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ = occ_q;

endmodule

// File: tb/tb_addsub_exec_unit.sv
// Directed bench for addsub_exec_unit at default parameters (LAT=2, Q_DEPTH=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_addsub_exec_unit;
  import tomasulo_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_func;
  logic [7:0] in_rs1;
  logic [7:0] in_rs2;
  logic [2:0] in_rob;
  logic [2:0] in_rs_idx;
  logic [3:0] in_rd;
  logic       cdb_valid;
  logic       cdb_ready;
  logic [7:0] cdb_result;
  logic       cdb_carry;
  logic       cdb_illegal;
  logic [2:0] cdb_rob;
  logic [2:0] cdb_rs_idx;
  logic [3:0] cdb_rd;
  logic [2:0] occ;

  addsub_exec_unit #(
    .DATA_W(8), .TAG_W(3), .RS_W(3), .REG_W(4), .LAT(2), .Q_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rob(in_rob),
    .in_rs_idx(in_rs_idx), .in_rd(in_rd),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_result(cdb_result),
    .cdb_carry(cdb_carry), .cdb_illegal(cdb_illegal), .cdb_rob(cdb_rob),
    .cdb_rs_idx(cdb_rs_idx), .cdb_rd(cdb_rd), .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] func;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rob;
    logic [2:0] rsi;
    logic [3:0] rd;
    logic [7:0] res;
    logic       c;
    logic       ill;
  } vec_t;

  vec_t vt [11];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] rob,
                       input logic [2:0] rsi, input logic [3:0] rd);
    in_valid  = v;
    in_func   = f;
    in_rs1    = a;
    in_rs2    = b;
    in_rob    = rob;
    in_rs_idx = rsi;
    in_rd     = rd;
  endtask

  // Idle drive with junk operands so a captured op cannot lean on live inputs.
  task automatic drive_idle();
    drive(1'b0, 4'hF, 8'h5A, 8'hA5, 3'd7, 3'd7, 4'hF);
  endtask

  // One op with cdb_ready high: exact latency 2, all fields, then occ back to 0.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    cdb_ready = 1'b1;
    drive(1'b1, v.func, v.a, v.b, v.rob, v.rsi, v.rd);
    mid();
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    next_cyc();
    drive_idle();
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      lat++;
      if (cdb_valid) break;
      next_cyc();
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd2);
    chk($sformatf("v%0d_result", idx), 32'(cdb_result), 32'(v.res));
    chk($sformatf("v%0d_carry", idx), 32'(cdb_carry), 32'(v.c));
    chk($sformatf("v%0d_illegal", idx), 32'(cdb_illegal), 32'(v.ill));
    chk($sformatf("v%0d_tags", idx), 32'({cdb_rob, cdb_rs_idx, cdb_rd}),
        32'({v.rob, v.rsi, v.rd}));
    next_cyc();
    mid();
    chk($sformatf("v%0d_occ_after", idx), 32'(occ), 32'd0);
    chk($sformatf("v%0d_valid_after", idx), 32'(cdb_valid), 32'd0);
    next_cyc();
  endtask

  // Three ops parked with cdb_ready low, then kill by flush or by reset.
  task automatic kill_seq(input logic use_rst, input string tag);
    int ghosts;
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, FUNC_ADD, 8'(8'h21 + i), 8'h00, 3'(i), 3'(i), 4'(i));
      next_cyc();
    end
    drive(1'b1, FUNC_ADD, 8'h77, 8'h00, 3'd6, 3'd6, 4'd6);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    mid();
    chk({tag, "_pre_valid"}, 32'(cdb_valid), 32'd1);
    if (!use_rst) chk({tag, "_in_ready_during"}, 32'(in_ready), 32'd0);
    next_cyc();
    rst   = 1'b0;
    flush = 1'b0;
    drive_idle();
    cdb_ready = 1'b1;
    mid();
    chk({tag, "_valid"}, 32'(cdb_valid), 32'd0);
    chk({tag, "_occ"}, 32'(occ), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    ghosts = 0;
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      mid();
      if (cdb_valid) ghosts++;
    end
    chk({tag, "_ghost_results"}, 32'(ghosts), 32'd0);
    next_cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        func      a      b      rob   rsi   rd     res    c     ill
    vt[0]  = '{FUNC_ADD, 8'h7F, 8'h01, 3'd5, 3'd2, 4'd3,  8'h80, 1'b0, 1'b0};
    vt[1]  = '{FUNC_SUB, 8'h03, 8'h05, 3'd1, 3'd0, 4'd1,  8'hFE, 1'b1, 1'b0};
    vt[2]  = '{FUNC_SUB, 8'h05, 8'h05, 3'd2, 3'd1, 4'd2,  8'h00, 1'b0, 1'b0};
    vt[3]  = '{FUNC_ADD, 8'hFF, 8'h01, 3'd3, 3'd4, 4'd15, 8'h00, 1'b1, 1'b0};
    vt[4]  = '{FUNC_AND, 8'hF0, 8'h3C, 3'd4, 3'd5, 4'd6,  8'h30, 1'b0, 1'b0};
    vt[5]  = '{FUNC_OR,  8'hF0, 8'h0C, 3'd6, 3'd6, 4'd7,  8'hFC, 1'b0, 1'b0};
    vt[6]  = '{FUNC_XOR, 8'hAA, 8'hFF, 3'd7, 3'd7, 4'd8,  8'h55, 1'b0, 1'b0};
    vt[7]  = '{4'hF,     8'hAA, 8'h55, 3'd0, 3'd3, 4'd9,  8'h00, 1'b0, 1'b1};
    vt[8]  = '{4'h5,     8'h12, 8'h34, 3'd1, 3'd2, 4'd10, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{FUNC_SUB, 8'h00, 8'h01, 3'd2, 3'd3, 4'd11, 8'hFF, 1'b1, 1'b0};
    vt[10] = '{FUNC_ADD, 8'h80, 8'h80, 3'd4, 3'd1, 4'd12, 8'h00, 1'b1, 1'b0};

    rst       = 1'b1;
    flush     = 1'b0;
    cdb_ready = 1'b0;
    drive_idle();
    repeat (3) next_cyc();
    rst = 1'b0;
    mid();
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_data", 32'({cdb_result, cdb_carry, cdb_illegal, cdb_rob, cdb_rs_idx, cdb_rd}),
        32'd0);
    next_cyc();

    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // Backpressure: four ADDs fill the unit, head holds, then drains in order.
    cdb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, FUNC_ADD, 8'(i + 1), 8'(i + 1), 3'(i), 3'(i), 4'(i));
      mid();
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd1);
      next_cyc();
    end
    drive(1'b1, FUNC_ADD, 8'h05, 8'h05, 3'd4, 3'd4, 4'd4);
    mid();
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_full_occ", 32'(occ), 32'd4);
    next_cyc();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("bp_hold_valid_%0d", i), 32'(cdb_valid), 32'd1);
      chk($sformatf("bp_hold_head_%0d", i), 32'({cdb_result, cdb_rob}), 32'({8'h02, 3'd0}));
      next_cyc();
    end
    cdb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("bp_drain_valid_%0d", i), 32'(cdb_valid), 32'd1);
      chk($sformatf("bp_drain_result_%0d", i), 32'(cdb_result), 32'(2 * (i + 1)));
      next_cyc();
    end
    mid();
    chk("bp_empty_valid", 32'(cdb_valid), 32'd0);
    chk("bp_empty_occ", 32'(occ), 32'd0);
    next_cyc();

    // Simultaneous accept and pop at occ=3.
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, FUNC_ADD, 8'(16 * (i + 1)), 8'h00, 3'(i), 3'(i), 4'(i));
      next_cyc();
    end
    drive_idle();
    mid();
    chk("ap_occ_before", 32'(occ), 32'd3);
    chk("ap_head_before", 32'(cdb_result), 32'h10);
    next_cyc();
    drive(1'b1, FUNC_ADD, 8'h40, 8'h00, 3'd3, 3'd3, 4'd3);
    cdb_ready = 1'b1;
    mid();
    chk("ap_in_ready", 32'(in_ready), 32'd1);
    chk("ap_occ_same_cycle", 32'(occ), 32'd3);
    chk("ap_pop_head", 32'(cdb_result), 32'h10);
    next_cyc();
    drive_idle();
    mid();
    chk("ap_occ_after", 32'(occ), 32'd3);
    chk("ap_order_1", 32'(cdb_result), 32'h20);
    next_cyc();
    mid();
    chk("ap_order_2", 32'(cdb_result), 32'h30);
    next_cyc();
    mid();
    chk("ap_order_3", 32'({cdb_valid, cdb_result}), 32'({1'b1, 8'h40}));
    next_cyc();
    mid();
    chk("ap_empty", 32'({cdb_valid, occ}), 32'd0);
    next_cyc();

    kill_seq(1'b0, "flush");
    run_vec(vt[0], 100);
    kill_seq(1'b1, "reset");
    run_vec(vt[1], 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_exec_unit.md
# addsub_exec_unit

Parametrised, pipelined integer add/sub/logic functional unit for the Tomasulo back end. It accepts one issued reservation-station entry per cycle over a valid/ready handshake and computes over a configurable-latency pipeline. Results are buffered in an in-order result queue and broadcast to the common data bus (CDB) under a valid/ready grant. A flush input discards all in-flight work on mispredict or exception.

## Interface
- `DATA_W`, 8, operand/result width
- `TAG_W`, 3, ROB index width
- `RS_W`, 3, reservation-station index width
- `REG_W`, 4, destination register index width
- `LAT`, 2, pipeline latency in cycles, ≥1
- `Q_DEPTH`, 4, max operations held (pipeline + result queue), ≥1
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: synchronous kill of all in-flight and queued operations
- `in_valid` in 1: issue request
- `in_ready` out 1: unit can accept
- `in_func` in 4: operation code
- `in_rs1`, `in_rs2` in DATA_W: operand values
- `in_rob` in TAG_W: ROB tag
- `in_rs_idx` in RS_W: issuing RS slot
- `in_rd` in REG_W: destination register
- `cdb_valid` out 1: result at queue head
- `cdb_ready` in 1: CDB grant
- `cdb_result` out DATA_W: result
- `cdb_carry` out 1: carry (add) / borrow (sub), 0 otherwise
- `cdb_illegal` out 1: unsupported func
- `cdb_rob`, `cdb_rs_idx`, `cdb_rd` out: tag fields passed through unchanged
- `occ` out clog2(Q_DEPTH+1): operations currently held

## Operation
- func 0000 ADD: `{carry,result} = rs1 + rs2` computed at DATA_W+1 bits.
- func 0001 SUB: `result = rs1 − rs2` mod 2^DATA_W; `carry = (rs1 < rs2)` unsigned.
- func 0010 AND, 0011 OR, 0100 XOR: `carry = 0`.
- Any other func: `result = 0`, `carry = 0`, `illegal = 1`. The operation is still broadcast so the ROB can retire it as an exception.
- Accept occurs when `in_valid && in_ready`. `in_ready = (occ < Q_DEPTH) && !flush`. There is no combinational path from `cdb_ready` to `in_ready`.
- `occ` increments on accept and decrements on pop (`cdb_valid && cdb_ready`). A simultaneous accept and pop leaves it unchanged.
- Results leave strictly in issue order.
- Flush or reset: all pipeline valids, queue pointers and `occ` are cleared. An `in_valid` presented in the same cycle is dropped. No result from a killed operation ever appears on the CDB.
- The operands and tag captured at accept are used as they are. Later input changes do not affect that operation.

## Timing
- Accept in cycle T: the result is visible on `cdb_*` with `cdb_valid=1` from cycle T+LAT at earliest. Outputs are registered.
- `cdb_*` hold stable while `cdb_valid && !cdb_ready`.
- Throughput is 1 op/cycle when Q_DEPTH ≥ LAT+1 and `cdb_ready` stays high. A smaller Q_DEPTH throttles issue through `in_ready`.
- Queue pointers wrap modulo Q_DEPTH. Full is `occ == Q_DEPTH`; empty is `occ == 0`, which forces `cdb_valid = 0`.
- Reset values: `cdb_valid=0`, `in_ready=1` (first cycle after reset), `occ=0`, and all `cdb_*` data outputs 0.
- Flush has priority over accept and pop in the same cycle. The cycle after flush: `cdb_valid=0`, `occ=0`, `in_ready=1`.

## Structure
- Shared package `tomasulo_pkg` holds:
  - the func encoding constants (`FUNC_ADD`, `FUNC_SUB`, `FUNC_AND`, `FUNC_OR`, `FUNC_XOR`)
  - the CDB entry struct (result, carry, illegal, rob, rs_idx, rd)
- Sub-module `exec_result_fifo`: a parametrised synchronous FIFO of CDB entries with a flush input. It is instantiated with depth Q_DEPTH.
- The pipeline is a LAT-deep array of valid + entry registers. Computation happens in stage 0; later stages only delay.

## Test plan
All scenarios use defaults (DATA_W=8, LAT=2, Q_DEPTH=4).
- ADD 8'h7F+8'h01, rob=5, rd=3 issued at T with `cdb_ready=1` -> at T+2: `cdb_valid=1`, result 8'h80, carry 0, rob 5, rd 3. In the following cycle `occ=0`.
- SUB 8'h03−8'h05 -> result 8'hFE, carry 1. SUB 8'h05−8'h05 -> result 8'h00, carry 0.
- `cdb_ready=0`, four back-to-back ADDs (1+1, 2+2, 3+3, 4+4):
  - `in_ready` drops after the 4th accept and `occ=4`.
  - The head holds 8'h02 stable.
  - After `cdb_ready` rises, results 02, 04, 06, 08 drain one per cycle.
- At occ=3, the same cycle sees an accept and a pop -> `occ` stays 3 and ordering is preserved.
- Three ops in flight, `flush` pulsed with `in_valid=1` -> next cycle `cdb_valid=0`, `occ=0`, `in_ready=1`. No result from the killed ops or the dropped input appears over the next 10 cycles.
- func 4'b1111 with rs1=8'hAA -> broadcast with result 0, illegal 1.
- `rst` asserted mid-stream -> same outcome as the flush check.
